// File: rtl/instr_sequencer.sv
// instr_sequencer: holds a small program memory and issues instruction words
// (plus the mvi immediate) to the processor, pacing each issue on DONE.
//
// Handshake: RUN is a one-cycle issue strobe that presents DIN=instruction.
// For mvi the immediate follows on DIN in the next cycle with RUN low.
// DONE from the control unit is accepted only in the IMM and WAIT states.
// A DONE in any other cycle, including the RUN cycle itself, is ignored.
// If no DONE arrives within TIMEOUT cycles of the issue, the sequencer parks
// in ERROR.
module instr_sequencer #(
  parameter int WORD_W  = 9,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              CLOCK,
  input  logic              RESETN,
  input  logic              START,
  input  logic              LOADEN,
  input  logic [ADDR_W-1:0] LOADADDR,
  input  logic [WORD_W-1:0] LOADDATA,
  input  logic              DONE,
  output logic [WORD_W-1:0] DIN,
  output logic              RUN,
  output logic [ADDR_W-1:0] PC,
  output logic              BUSY,
  output logic              HALTED,
  output logic              ERR,
  output logic [3:0]        state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_FETCHIMM = 4'd3,
    S_ISSUE    = 4'd4,
    S_IMM      = 4'd5,
    S_WAIT     = 4'd6,
    S_HALT     = 4'd7,
    S_ERROR    = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] irbuf_q;
  logic [WORD_W-1:0] immbuf_q;
  logic [WORD_W-1:0] din_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        rd_op;
  logic [2:0]        ir_op;
  logic              parked;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign rd_op  = rdata_q[WORD_W-1 -: 3];
  assign ir_op  = irbuf_q[WORD_W-1 -: 3];
  assign parked = (state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERROR);
  // In DECODE the immediate (if any) sits at the incremented PC, so read ahead.
  assign rd_addr = (state_q == S_DECODE) ? pc_inc : pc_q;

  // Program memory write port: the loader may only write while the sequencer is parked.
  always_ff @(posedge CLOCK) begin
    if (LOADEN && parked) begin
      mem[LOADADDR] <= LOADDATA;
    end
  end

  // Synchronous read port, one cycle of latency.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[rd_addr];
    end
  end

  // State register.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (START) state_d = S_FETCH;
      end
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        if (rd_op == OP_HALT)     state_d = S_HALT;
        else if (rd_op == OP_MVI) state_d = S_FETCHIMM;
        else                      state_d = S_ISSUE;
      end
      S_FETCHIMM: state_d = S_ISSUE;
      S_ISSUE:    state_d = (ir_op == OP_MVI) ? S_IMM : S_WAIT;
      S_IMM:      state_d = DONE ? S_FETCH : S_WAIT;
      S_WAIT: begin
        if (DONE)                                 state_d = S_FETCH;
        else if (cnt_q >= CNT_W'(TIMEOUT - 1))    state_d = S_ERROR;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath: program counter, instruction/immediate buffers, held DIN and the DONE timeout counter.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      pc_q     <= '0;
      irbuf_q  <= '0;
      immbuf_q <= '0;
      din_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT, S_ERROR: begin
          if (START) pc_q <= '0;
        end
        S_DECODE: begin
          irbuf_q <= rdata_q;
          pc_q    <= pc_inc;
        end
        S_FETCHIMM: begin
          immbuf_q <= rdata_q;
          pc_q     <= pc_inc;
        end
        S_ISSUE: begin
          // Counter value equals the number of cycles elapsed since the issue cycle.
          din_q <= irbuf_q;
          cnt_q <= CNT_W'(1);
        end
        S_IMM: begin
          din_q <= immbuf_q;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Output decode: DIN shows the word being presented, otherwise it holds the last one.
  always_comb begin
    DIN = din_q;
    if (state_q == S_ISSUE)    DIN = irbuf_q;
    else if (state_q == S_IMM) DIN = immbuf_q;
  end

  assign RUN       = (state_q == S_ISSUE);
  assign PC        = pc_q;
  assign BUSY      = !parked;
  assign HALTED    = (state_q == S_HALT);
  assign ERR       = (state_q == S_ERROR);
  assign state_dbg = state_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Initiator side of the processor instruction interface: holds a small program memory and issues 9-bit instruction words in IIIXXXYYY format on DIN with a RUN strobe.
- Supplies the immediate word for mvi, then waits for the control unit's DONE before issuing the next instruction.
- Sits between the board switches/loader and the processor; stops on a halt opcode or on a DONE timeout.

Parameters:
- WORD_W, 9, instruction/data word width (opcode = top 3 bits).
- DEPTH, 32, program memory words.
- ADDR_W, 5, program counter width (2^ADDR_W = DEPTH).
- TIMEOUT, 15, maximum cycles to wait for DONE after issue (at least 2).

Ports:
- CLOCK  in  1  single system clock, rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse: run program from address 0.
- LOADEN  in  1  program memory write enable.
- LOADADDR  in  ADDR_W  write address.
- LOADDATA  in  WORD_W  write data.
- DONE  in  1  instruction-complete strobe from the control unit.
- DIN  out  WORD_W  instruction or immediate word to the processor.
- RUN  out  1  high for exactly the instruction-issue cycle.
- PC  out  ADDR_W  address of the next word to fetch.
- BUSY  out  1  high in every state except IDLE, HALT and ERROR.
- HALTED  out  1  a halt opcode (111) was reached.
- ERR  out  1  DONE timeout occurred.

Behaviour:
- Reset (asynchronous, RESETN=0): state IDLE; DIN=0, RUN=0, PC=0, BUSY=0, HALTED=0, ERR=0; internal buffers and timeout counter cleared. Memory contents are not reset.
- Memory: synchronous write when LOADEN=1 and state is IDLE, HALT or ERROR; LOADEN is ignored otherwise. Read is synchronous with 1-cycle latency.
- States:
  - IDLE: waits for START.
  - FETCH: memory address = PC.
  - DECODE: read word captured into IRBUF; PC<=PC+1.
    - Opcode 111: go to HALT, HALTED=1.
    - Opcode 001 (mvi): go to FETCHIMM, memory address = new PC.
    - Otherwise: go to ISSUE.
  - FETCHIMM: captures IMMBUF; PC<=PC+1; go to ISSUE.
  - ISSUE: DIN=IRBUF, RUN=1 for this one cycle. Next state is IMM if mvi, else WAIT.
  - IMM: DIN=IMMBUF, RUN=0. If DONE=1 go to FETCH, else WAIT.
  - WAIT: DIN holds its last value. DONE=1 goes to FETCH. A cycle counter runs from the cycle after ISSUE; when it reaches TIMEOUT with no DONE, go to ERROR, ERR=1.
  - HALT / ERROR: sticky. START clears HALTED/ERR, sets PC=0 and goes to FETCH.
- DONE is honoured only in IMM and WAIT. DONE in any other state, including ISSUE, is ignored.
- START in IDLE, HALT or ERROR: PC<=0, go to FETCH. START while BUSY is ignored.
- PC wraps from DEPTH-1 to 0, including an mvi whose immediate sits at address 0.
- LOADEN and START in the same cycle: the write completes that cycle; the fetch reads memory the following cycle, so it sees the new data.
- Issue latency from START: RUN rises 3 cycles later for non-mvi (FETCH, DECODE, ISSUE) and 4 cycles later for mvi.
- RESETN asserted mid-instruction aborts immediately to IDLE with outputs at reset values.

Test Plan:
- Program [0]=010_000_001 (add), [1]=111_000_000; pulse START; DONE 2 cycles after RUN -> RUN pulses once with DIN=9'h081, then HALTED=1, BUSY=0, PC=2.
- Program [0]=001_011_000 (mvi R3), [1]=9'h0A5, [2]=halt; DONE asserted in the IMM cycle -> ISSUE cycle DIN=9'h058, RUN=1; next cycle DIN=9'h0A5, RUN=0; then HALTED=1, PC=3.
- Program [0]=000_001_010 (mv); DONE never asserted -> ERR=1 exactly TIMEOUT=15 cycles after ISSUE, RUN never re-asserts; START then restarts from PC=0 with ERR=0.
- Fill all 32 words with mv (000_000_001), respond DONE each time -> PC wraps 31->0 and issue continues; a START pulse while BUSY has no effect.
- LOADEN with LOADADDR=3, LOADDATA=9'h1FF during WAIT -> the write is dropped and word 3 still holds the original instruction when executed.
- Drop RESETN during the IMM cycle -> RUN=0, DIN=0, PC=0, BUSY=0 immediately, with no clock edge required.
